// File: rtl/noc_avst_depacketizer_pkg.sv
// Shared types and field-offset helpers for the NoC bundle to Avalon-ST depacketizer.
// Offsets are bit positions inside a single flit, counted from the flit LSB.
package noc_avst_depacketizer_pkg;

    localparam int DEF_DATA_WIDTH = 512;
    localparam int DEF_EW         = 6;
    localparam int PKTID_W        = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic                      sop;
        logic                      eop;
        logic [DEF_EW-1:0]         empty;
        logic                      error;
        logic [PKTID_W-1:0]        pktid;
        logic                      flag;
    } beat_t;

    function automatic int valid_pos(input int fw);
        return fw - 1;
    endfunction

    function automatic int head_pos(input int fw);
        return fw - 2;
    endfunction

    function automatic int tail_pos(input int fw);
        return fw - 3;
    endfunction

    function automatic int vc_msb(input int fw);
        return fw - 4;
    endfunction

    function automatic int payload_w(input int fw, input int vcw);
        return fw - 3 - vcw;
    endfunction

    // Top-flit header fields sit at the MSB end of that flit's payload.
    function automatic int dest_msb(input int fw, input int vcw);
        return payload_w(fw, vcw) - 1;
    endfunction

    function automatic int flag_pos(input int fw, input int vcw, input int aw);
        return payload_w(fw, vcw) - 1 - aw;
    endfunction

    function automatic int pktid_msb(input int fw, input int vcw, input int aw);
        return payload_w(fw, vcw) - 2 - aw;
    endfunction

    function automatic int empty_msb(input int fw, input int vcw, input int aw);
        return payload_w(fw, vcw) - 2 - aw - PKTID_W;
    endfunction

    function automatic int top_data_w(input int fw, input int vcw, input int aw, input int ew);
        return payload_w(fw, vcw) - aw - 1 - PKTID_W - ew;
    endfunction

endpackage

// File: rtl/avst_skid_buffer.sv
// Generic 2-entry registered skid buffer: output register plus one skid slot.
// in_ready is a flop, so out_ready never reaches in_ready combinationally.
module avst_skid_buffer
    import noc_avst_depacketizer_pkg::*;
#(
    parameter type T = beat_t
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both 1;
    // valid and data are held steady until that edge.
    T     skid_data;
    logic skid_valid;
    logic skid_valid_d;
    logic ready_q;
    logic push;
    logic out_free;

    assign push     = in_valid & ready_q;
    assign out_free = out_ready | ~out_valid;
    assign in_ready = ready_q;

    always_comb begin
        skid_valid_d = skid_valid;
        if (out_free) begin
            skid_valid_d = 1'b0;
        end else if (push) begin
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            skid_valid <= skid_valid_d;
            ready_q    <= ~skid_valid_d;
            if (out_free) begin
                // A parked beat is older than anything arriving now, so it goes first.
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= skid_data;
                end else begin
                    out_valid <= push;
                    if (push) begin
                        out_data <= in_data;
                    end
                end
            end else if (push) begin
                skid_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/noc_avst_depacketizer.sv
// Unpacks a NUM_FLITS-wide NoC bundle into one Avalon-ST beat, tracks packet
// framing (IDLE/IN_PKT), latches packet id/flag on sop and keeps statistics.
module noc_avst_depacketizer
    import noc_avst_depacketizer_pkg::*;
#(
    parameter int DATA_WIDTH = 512,
    parameter int NUM_FLITS  = 4,
    parameter int FLIT_WIDTH = 150,
    parameter int NUM_VC     = 2,
    parameter int NOC_RADIX  = 16,
    parameter int CNT_WIDTH  = 16,
    localparam int WIDTH_IN  = NUM_FLITS * FLIT_WIDTH,
    localparam int EW        = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH_IN-1:0]   i_data_in,
    input  logic                  i_valid_in,
    output logic                  i_ready_out,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic [EW-1:0]         out_empty,
    output logic                  out_error,
    output logic [31:0]           o_pktid_out,
    output logic                  o_payload_flag,
    output logic [CNT_WIDTH-1:0]  o_pkt_count,
    output logic [CNT_WIDTH-1:0]  o_drop_count,
    output state_t                dbg_state
);

    localparam int VCW       = $clog2(NUM_VC);
    localparam int AW        = $clog2(NOC_RADIX);
    localparam int PW        = payload_w(FLIT_WIDTH, VCW);
    localparam int TDW       = top_data_w(FLIT_WIDTH, VCW, AW, EW);
    localparam int TOTAL_PW  = TDW + (NUM_FLITS - 1) * PW;
    localparam int VALID_POS = valid_pos(FLIT_WIDTH);
    localparam int HEAD_POS  = head_pos(FLIT_WIDTH);
    localparam int TAIL_POS  = tail_pos(FLIT_WIDTH);
    localparam int FLAG_POS  = flag_pos(FLIT_WIDTH, VCW, AW);
    localparam int PKTID_MSB = pktid_msb(FLIT_WIDTH, VCW, AW);
    localparam int EMPTY_MSB = empty_msb(FLIT_WIDTH, VCW, AW);

    generate
        if (NUM_FLITS < 2) begin : g_bad_flits
            $error("noc_avst_depacketizer: NUM_FLITS must be at least 2");
        end
        if (TOTAL_PW < DATA_WIDTH) begin : g_bad_width
            $error("noc_avst_depacketizer: bundle payload narrower than DATA_WIDTH");
        end
    endgenerate

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  sop;
        logic                  eop;
        logic [EW-1:0]         empty;
        logic                  error;
        logic [PKTID_W-1:0]    pktid;
        logic                  flag;
    } beat_w_t;

    logic [FLIT_WIDTH-1:0] top_flit;
    logic [FLIT_WIDTH-1:0] flit0;
    logic [TOTAL_PW-1:0]   pay_all;
    logic                  top_valid;
    logic                  sop;
    logic                  eop;
    logic                  f_flag;
    logic [PKTID_W-1:0]    f_pktid;
    logic [EW-1:0]         f_empty;

    assign top_flit  = i_data_in[WIDTH_IN-1 -: FLIT_WIDTH];
    assign flit0     = i_data_in[FLIT_WIDTH-1:0];
    assign top_valid = top_flit[VALID_POS];
    assign sop       = top_flit[HEAD_POS];
    assign eop       = flit0[TAIL_POS];
    assign f_flag    = top_flit[FLAG_POS];
    assign f_pktid   = top_flit[PKTID_MSB -: PKTID_W];
    assign f_empty   = top_flit[EMPTY_MSB -: EW];

    // Payloads concatenate top-first; the beat takes the most significant DATA_WIDTH bits.
    always_comb begin
        pay_all = '0;
        pay_all[TOTAL_PW-1 -: TDW] = top_flit[TDW-1:0];
        for (int k = 0; k < NUM_FLITS - 1; k++) begin
            pay_all[k*PW +: PW] = i_data_in[k*FLIT_WIDTH +: PW];
        end
    end

    // VC, dest, lower-flit control bits and payload below DATA_WIDTH are not forwarded.
    logic unused_bits;
    assign unused_bits = ^{i_data_in, pay_all};

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               beat_vld;
    logic               fwd;
    logic               drop;
    logic               beat_err;
    logic [PKTID_W-1:0] pktid_q;
    logic               flag_q;
    beat_w_t            beat_in;
    beat_w_t            beat_out;

    assign accept   = i_valid_in & i_ready_out;
    assign beat_vld = accept & top_valid;

    always_comb begin
        state_d  = state_q;
        fwd      = 1'b0;
        drop     = 1'b0;
        beat_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (beat_vld) begin
                    if (sop) begin
                        fwd = 1'b1;
                        if (!eop) begin
                            state_d = ST_IN_PKT;
                        end
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            ST_IN_PKT: begin
                if (beat_vld) begin
                    fwd      = 1'b1;
                    // A fresh head here means the open packet lost its tail.
                    beat_err = sop;
                    state_d  = eop ? ST_IDLE : ST_IN_PKT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pktid_q <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (fwd && sop) begin
                pktid_q <= f_pktid;
                flag_q  <= f_flag;
            end
        end
    end

    always_comb begin
        beat_in       = '0;
        beat_in.data  = pay_all[TOTAL_PW-1 -: DATA_WIDTH];
        beat_in.sop   = sop;
        beat_in.eop   = eop;
        beat_in.empty = eop ? f_empty : '0;
        beat_in.error = beat_err;
        beat_in.pktid = sop ? f_pktid : pktid_q;
        beat_in.flag  = sop ? f_flag : flag_q;
    end

    avst_skid_buffer #(
        .T(beat_w_t)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (fwd),
        .in_ready (i_ready_out),
        .in_data  (beat_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (beat_out)
    );

    assign out_data       = beat_out.data;
    assign out_sop        = beat_out.sop;
    assign out_eop        = beat_out.eop;
    assign out_empty      = beat_out.empty;
    assign out_error      = beat_out.error;
    assign o_pktid_out    = beat_out.pktid;
    assign o_payload_flag = beat_out.flag;

    logic [CNT_WIDTH-1:0] pkt_cnt_q;
    logic [CNT_WIDTH-1:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (out_valid && out_ready && beat_out.eop && (pkt_cnt_q != '1)) begin
                pkt_cnt_q <= pkt_cnt_q + CNT_WIDTH'(1);
            end
            if (drop && (drop_cnt_q != '1)) begin
                drop_cnt_q <= drop_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign o_pkt_count  = pkt_cnt_q;
    assign o_drop_count = drop_cnt_q;
    assign dbg_state    = state_q;

endmodule
